// File: rtl/text_pkg.sv
// Shared constants, cell layout and FSM encoding for the text-plane write path.
package text_pkg;

  localparam int COLS   = 120;
  localparam int ROWS   = 61;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 18;

  localparam int CHAR_LSB = 0;
  localparam int CHAR_MSB = 7;
  localparam int FG_LSB   = 8;
  localparam int FG_MSB   = 11;
  localparam int BG_LSB   = 12;
  localparam int BG_MSB   = 15;
  localparam int BL_LSB   = 16;
  localparam int BL_MSB   = 17;

  localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_CSETUP  = 3'd3,
    ST_CSTROBE = 3'd4
  } arb_state_e;

  function automatic logic [DATA_W-1:0] cell_word(input logic [1:0] bl,
                                                  input logic [3:0] bg,
                                                  input logic [3:0] fg,
                                                  input logic [7:0] ch);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CHAR_MSB:CHAR_LSB] = ch;
    w[FG_MSB:FG_LSB]     = fg;
    w[BG_MSB:BG_LSB]     = bg;
    w[BL_MSB:BL_LSB]     = bl;
    return w;
  endfunction

endpackage

// File: rtl/text_write_arbiter_rr.sv
// Combinational round-robin pick: first valid index strictly after the pointer, cyclically.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    any_o   = 1'b0;
    idx_o   = '0;
    grant_o = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_write_arbiter.sv
// Round-robin sharing of the TextGraphic write port with a built-in screen-clear sequencer.
module text_write_arbiter
  import text_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk50,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          ReqValid,
  output logic [NREQ-1:0]          ReqReady,
  input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
  input  logic [NREQ*DATA_W-1:0]   ReqData,
  input  logic                     ClearStart,
  input  logic [DATA_W-1:0]        ClearData,
  output logic                     ClearBusy,
  output logic                     ClearDone,
  output logic                     AddrErr,
  output logic [ADDR_W-1:0]        WAddr,
  output logic [DATA_W-1:0]        WData,
  output logic                     Write
);

  localparam int IW = $clog2(NREQ);

  arb_state_e          state_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic                busy_q;
  logic                pend_q;
  logic                done_q;
  logic                err_q;
  logic [IW-1:0]       ptr_q;

  logic [NREQ-1:0]     gnt_oh;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                clr_req;
  logic                clr_go;
  logic                grant_ok;
  logic                addr_bad;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .valid_i (ReqValid),
    .ptr_i   (ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr = ReqAddr[i*ADDR_W +: ADDR_W];
        sel_data = ReqData[i*DATA_W +: DATA_W];
      end
    end
  end

  // A clear request arriving in IDLE pre-empts any same-cycle grant.
  assign clr_req  = ClearStart && !busy_q;
  assign clr_go   = (state_q == ST_IDLE) && (pend_q || clr_req);
  assign grant_ok = (state_q == ST_IDLE) && !clr_go && gnt_any;
  assign addr_bad = (sel_addr >= CELLS_A);
  assign ReqReady = (grant_ok && !Reset) ? gnt_oh : '0;

  always_ff @(posedge clk50 or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      done_q <= 1'b0;
      if (clr_req) busy_q <= 1'b1;
      if (clr_req && !clr_go) pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (clr_go) begin
            pend_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= ClearData;
            state_q <= ST_CSETUP;
          end else if (grant_ok) begin
            ptr_q <= gnt_idx;
            if (addr_bad) begin
              err_q <= 1'b1;
            end else begin
              waddr_q <= sel_addr;
              wdata_q <= sel_data;
              state_q <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          write_q <= 1'b1;
          state_q <= ST_STROBE;
        end
        ST_STROBE: begin
          write_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_CSETUP: begin
          write_q <= 1'b1;
          state_q <= ST_CSTROBE;
        end
        ST_CSTROBE: begin
          write_q <= 1'b0;
          if (waddr_q == LAST_ADDR) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            waddr_q <= waddr_q + ADDR_W'(1);
            state_q <= ST_CSETUP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign WAddr     = waddr_q;
  assign WData     = wdata_q;
  assign Write     = write_q;
  assign ClearBusy = busy_q;
  assign ClearDone = done_q;
  assign AddrErr   = err_q;

endmodule

// File: tb/tb_text_write_arbiter.sv
// Directed bench for text_write_arbiter: grants, fairness, illegal address, clears and reset.
module tb_text_write_arbiter;
  import text_pkg::*;

  localparam int NREQ = 4;

  logic                   clk50 = 1'b0;
  logic                   Reset;
  logic [NREQ-1:0]        ReqValid;
  logic [NREQ-1:0]        ReqReady;
  logic [NREQ*ADDR_W-1:0] ReqAddr;
  logic [NREQ*DATA_W-1:0] ReqData;
  logic                   ClearStart;
  logic [DATA_W-1:0]      ClearData;
  logic                   ClearBusy;
  logic                   ClearDone;
  logic                   AddrErr;
  logic [ADDR_W-1:0]      WAddr;
  logic [DATA_W-1:0]      WData;
  logic                   Write;

  int checks   = 0;
  int failures = 0;

  text_write_arbiter #(.NREQ(NREQ)) dut (
    .clk50      (clk50),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqAddr    (ReqAddr),
    .ReqData    (ReqData),
    .ClearStart (ClearStart),
    .ClearData  (ClearData),
    .ClearBusy  (ClearBusy),
    .ClearDone  (ClearDone),
    .AddrErr    (AddrErr),
    .WAddr      (WAddr),
    .WData      (WData),
    .Write      (Write)
  );

  always #5 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ReqAddr[i*ADDR_W +: ADDR_W] = a;
    ReqData[i*DATA_W +: DATA_W] = d;
  endtask

  // Samples from the current cycle until ClearDone, then one cycle more.
  task automatic clear_run(input int exp_busy, input logic [DATA_W-1:0] exp_data);
    int strobes = 0;
    int busy = 0;
    int bad = 0;
    int rdy = 0;
    int consec = 0;
    int dones = 0;
    logic prev = 1'b0;
    logic [ADDR_W-1:0] nxt = '0;
    for (int c = 0; c < 20000; c++) begin
      if (ClearBusy) busy++;
      if (ClearBusy && ReqReady != '0) rdy++;
      if (Write) begin
        if (WAddr !== nxt || WData !== exp_data) bad++;
        if (prev) consec++;
        nxt++;
        strobes++;
      end
      prev = Write;
      if (ClearDone) begin
        ReqValid = '0;
        dones++;
        break;
      end
      step();
    end
    chk("clr_strobes", strobes, CELLS);
    chk("clr_order", bad, 0);
    chk("clr_busy_cycles", busy, exp_busy);
    chk("clr_done_seen", dones, 1);
    chk("clr_ready_stall", rdy, 0);
    chk("clr_write_consec", consec, 0);
    chk("clr_busy_low", ClearBusy, 0);
    step();
    chk("clr_done_pulse", ClearDone, 0);
  endtask

  initial begin
    int exp_g;
    int found;
    Reset      = 1'b1;
    ReqValid   = '0;
    ReqAddr    = '0;
    ReqData    = '0;
    ClearStart = 1'b0;
    ClearData  = '0;
    step();
    step();
    ReqValid = 4'b1111;
    #1;
    chk("rst_ready", ReqReady, 0);
    chk("rst_write", Write, 0);
    chk("rst_waddr", WAddr, 0);
    chk("rst_wdata", WData, 0);
    chk("rst_busy", ClearBusy, 0);
    chk("rst_done", ClearDone, 0);
    chk("rst_err", AddrErr, 0);
    ReqValid = '0;
    step();
    Reset = 1'b0;
    step();

    // single request from requester 0
    set_req(0, 13'd5, 18'h0F041);
    ReqValid = 4'b0001;
    #1;
    chk("single_ready", ReqReady, 4'b0001);
    step();
    ReqValid = '0;
    chk("single_setup_write", Write, 0);
    chk("single_setup_waddr", WAddr, 5);
    chk("single_setup_wdata", WData, 18'h0F041);
    step();
    chk("single_strobe_write", Write, 1);
    chk("single_strobe_waddr", WAddr, 5);
    chk("single_strobe_wdata", WData, 18'h0F041);
    step();
    chk("single_after_write", Write, 0);

    // fairness with all requesters valid; pointer now sits at 0
    for (int i = 0; i < NREQ; i++)
      set_req(i, ADDR_W'(10 + i), cell_word(2'(i), 4'(i), 4'hA, 8'(8'h40 + i)));
    ReqValid = 4'b1111;
    #1;
    for (int g = 0; g < 8; g++) begin
      exp_g = (1 + g) % NREQ;
      chk("fair_grant", ReqReady, 4'b0001 << exp_g);
      step();
      chk("fair_setup_ready", ReqReady, 0);
      chk("fair_setup_write", Write, 0);
      step();
      chk("fair_strobe_write", Write, 1);
      chk("fair_strobe_waddr", WAddr, 10 + exp_g);
      chk("fair_strobe_wdata", WData,
          cell_word(2'(exp_g), 4'(exp_g), 4'hA, 8'(8'h40 + exp_g)));
      step();
    end
    ReqValid = '0;

    // illegal address from requester 1
    set_req(1, 13'd7320, 18'h12345);
    ReqValid = 4'b0010;
    #1;
    chk("illegal_ready", ReqReady, 4'b0010);
    step();
    ReqValid = '0;
    chk("illegal_err", AddrErr, 1);
    chk("illegal_nowrite1", Write, 0);
    step();
    chk("illegal_nowrite2", Write, 0);
    step();
    chk("illegal_nowrite3", Write, 0);

    // highest legal address from requester 2; error stays sticky
    set_req(2, 13'd7319, 18'h2AAAA);
    ReqValid = 4'b0100;
    #1;
    chk("maxaddr_ready", ReqReady, 4'b0100);
    step();
    ReqValid = '0;
    step();
    chk("maxaddr_write", Write, 1);
    chk("maxaddr_waddr", WAddr, 7319);
    chk("err_sticky", AddrErr, 1);
    step();

    // clear requested during a requester's SETUP
    set_req(0, 13'd33, 18'h3FFFF);
    ReqValid = 4'b0001;
    #1;
    chk("mix_ready", ReqReady, 4'b0001);
    step();
    ReqValid   = '0;
    ClearStart = 1'b1;
    ClearData  = 18'h0155A;
    step();
    ClearStart = 1'b0;
    chk("mix_req_write", Write, 1);
    chk("mix_req_waddr", WAddr, 33);
    chk("mix_busy", ClearBusy, 1);
    step();
    ReqValid = 4'b0001;
    #1;
    clear_run(2 * CELLS + 1, 18'h0155A);

    // simultaneous ClearStart and requests in IDLE
    ReqValid   = 4'b1111;
    ClearStart = 1'b1;
    ClearData  = 18'h00020;
    #1;
    chk("same_cycle_ready", ReqReady, 0);
    step();
    ClearStart = 1'b0;
    chk("clr_setup_waddr", WAddr, 0);
    chk("clr_setup_wdata", WData, 18'h00020);
    chk("clr_setup_busy", ClearBusy, 1);
    clear_run(2 * CELLS, 18'h00020);

    // reset in the middle of a clear
    ClearStart = 1'b1;
    step();
    ClearStart = 1'b0;
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      if (Write && WAddr == 13'd100) begin
        found = 1;
        break;
      end
      step();
    end
    chk("reach_addr100", found, 1);
    chk("addr100_busy", ClearBusy, 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_write", Write, 0);
    chk("async_rst_busy", ClearBusy, 0);
    chk("async_rst_waddr", WAddr, 0);
    step();
    Reset    = 1'b0;
    ReqValid = 4'b1111;
    #1;
    chk("post_rst_grant", ReqReady, 4'b0001);
    chk("post_rst_err", AddrErr, 0);
    step();
    ReqValid = '0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
